// File: rtl/dmem_resp_if.sv
// Request/response bus between an initiator and the dmem_resp memory model.
// Initiator uses the master modport; the memory uses the slave modport.
interface dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/dmem_resp.sv
// Single-outstanding data memory with programmable wait states.
// A request is latched in IDLE, waits WAIT_CYCLES edges in BUSY, is performed
// on the following edge, and the resulting word is held in RESP until consumed.
// Writes merge enabled byte lanes and return the merged word.
module dmem_resp #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    dmem_resp_if.slave  bus,
    input  logic [31:0] test_addr,
    output logic [31:0] test_data
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Wait count fits a 4-bit counter (0..15).
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q,   cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q,   idx_d;
    logic [3:0]            wen_q,   wen_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;

    // Storage is not reset; it starts out all-zero.
    logic [31:0] mem_q [DEPTH] = '{default: '0};

    logic        accept;
    logic        do_access;
    logic [31:0] merged;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[31:DEPTH_LOG2+2], bus.req_addr[1:0],
                                test_addr[31:DEPTH_LOG2+2], test_addr[1:0]};

    // Handshake outputs decode straight from state; req_ready drops while in reset.
    assign bus.req_ready  = resetn && (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign accept         = bus.req_valid && bus.req_ready;

    // Combinational display port straight off the array.
    assign test_data = mem_q[test_addr[DEPTH_LOG2+1:2]];

    // Byte-lane merge of latched write data over the currently stored word.
    always_comb begin
        merged = mem_q[idx_q];
        for (int i = 0; i < 4; i++) begin
            if (wen_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // Next-state logic: latch on accept, count down wait states, then access.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        do_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    idx_d   = bus.req_addr[DEPTH_LOG2+1:2];
                    wen_d   = bus.req_wen;
                    wdata_d = bus.req_wdata;
                    cnt_d   = WAIT_CNT;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // For a read merged equals the stored word.
                    do_access = 1'b1;
                    rdata_d   = merged;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers, asynchronously cleared.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wen_q   <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array write on the access edge; reset forces IDLE so an aborted request never writes.
    always_ff @(posedge clk) begin
        if (resetn && do_access && (wen_q != 4'd0)) mem_q[idx_q] <= merged;
    end
endmodule

// File: tb/tb_dmem_resp.sv
// Randomized and directed checks of dmem_resp against a transaction-level model.
module tb_dmem_resp;
    localparam int W = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    dmem_resp_if b ();
    dmem_resp_if b0 ();
    logic [31:0] t_addr, t_data, t_addr0, t_data0;

    dmem_resp #(.WAIT_CYCLES(W), .DEPTH_LOG2(8)) dut (
        .clk(clk), .resetn(resetn), .bus(b), .test_addr(t_addr), .test_data(t_data));
    dmem_resp #(.WAIT_CYCLES(0), .DEPTH_LOG2(8)) dut0 (
        .clk(clk), .resetn(resetn), .bus(b0), .test_addr(t_addr0), .test_data(t_data0));

    logic [31:0] mdl  [256];
    logic [31:0] mdl0 [256];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Spec rule: enabled lanes take write data, others keep the old byte.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wen);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (wen[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic start_req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        chk("req_ready_idle", 32'(b.req_ready), 1);
        b.req_valid = 1'b1; b.req_wen = wen; b.req_addr = addr; b.req_wdata = wd;
        @(negedge clk);
        // Scribble over the request lines; the DUT must have latched already.
        b.req_valid = 1'b0; b.req_wen = 4'($urandom); b.req_addr = $urandom; b.req_wdata = $urandom;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!b.resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd,
                       input int hold);
        int lat;
        logic [7:0]  idx;
        logic [31:0] exp;
        idx = addr[9:2];
        if (wen != 4'd0) mdl[idx] = merge(mdl[idx], wd, wen);
        exp = mdl[idx];
        start_req(wen, addr, wd);
        wait_resp(lat);
        chk("latency", lat, W + 1);
        chk("rdata", b.resp_rdata, exp);
        t_addr = {22'($urandom), idx, 2'($urandom)};
        #1;
        chk("test_data", t_data, exp);
        for (int h = 0; h < hold; h++) begin
            b.req_valid = 1'b1; b.req_wen = 4'($urandom); b.req_addr = $urandom; b.req_wdata = $urandom;
            @(negedge clk);
            chk("hold_valid", 32'(b.resp_valid), 1);
            chk("hold_rdata", b.resp_rdata, exp);
            chk("hold_ready", 32'(b.req_ready), 0);
        end
        b.req_valid = 1'b0;
        b.resp_ready = 1'b1;
        @(negedge clk);
        b.resp_ready = 1'b0;
        chk("resp_done", 32'(b.resp_valid), 0);
        chk("ready_after", 32'(b.req_ready), 1);
    endtask

    // WAIT_CYCLES=0 instance: response one edge after accept, consumed on the next.
    task automatic txn0(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
        logic [7:0] idx;
        idx = addr[9:2];
        if (wen != 4'd0) mdl0[idx] = merge(mdl0[idx], wd, wen);
        @(negedge clk);
        b0.req_valid = 1'b1; b0.req_wen = wen; b0.req_addr = addr; b0.req_wdata = wd;
        b0.resp_ready = 1'b1;
        @(negedge clk);
        b0.req_valid = 1'b0;
        chk("w0_busy", 32'(b0.resp_valid), 0);
        @(negedge clk);
        chk("w0_valid", 32'(b0.resp_valid), 1);
        chk("w0_rdata", b0.resp_rdata, mdl0[idx]);
        @(negedge clk);
        chk("w0_done", 32'(b0.resp_valid), 0);
        b0.resp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] a, d;
        logic [3:0]  we;
        for (int i = 0; i < 256; i++) begin mdl[i] = '0; mdl0[i] = '0; end
        b.req_valid = 0; b.req_wen = 0; b.req_addr = 0; b.req_wdata = 0; b.resp_ready = 0;
        b0.req_valid = 0; b0.req_wen = 0; b0.req_addr = 0; b0.req_wdata = 0; b0.resp_ready = 0;
        t_addr = 0; t_addr0 = 0;
        resetn = 1'b0;
        #12;
        chk("rst_req_ready", 32'(b.req_ready), 0);
        chk("rst_resp_valid", 32'(b.resp_valid), 0);
        chk("rst_rdata", b.resp_rdata, 0);
        chk("rst_test_data", t_data, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(b.req_ready), 1);

        // Full write then read back.
        txn(4'hF, 32'h10, 32'hDEADBEEF, 0);
        txn(4'h0, 32'h10, 32'h0, 0);
        // Partial write merge.
        txn(4'hF, 32'h20, 32'h11223344, 0);
        txn(4'h5, 32'h20, 32'hAABBCCDD, 0);
        t_addr = 32'h20; #1;
        chk("merge_0x20", t_data, 32'h11BB33DD);
        // Long backpressure with a competing request.
        txn(4'h0, 32'h10, 32'h0, 10);
        // Aliased address.
        txn(4'hF, 32'h404, 32'hCAFEF00D, 0);
        t_addr = 32'h4; #1;
        chk("alias_0x4", t_data, 32'hCAFEF00D);

        // Reset in BUSY with cnt=1: write aborted.
        txn(4'hF, 32'h30, 32'h5A5A1234, 0);
        start_req(4'hF, 32'h30, 32'hFFFFFFFF);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("busy_rst_valid", 32'(b.resp_valid), 0);
        chk("busy_rst_ready", 32'(b.req_ready), 0);
        chk("busy_rst_rdata", b.resp_rdata, 0);
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        t_addr = 32'h30; #1;
        chk("busy_rst_word", t_data, 32'h5A5A1234);
        @(negedge clk);
        chk("busy_rst_ready_after", 32'(b.req_ready), 1);

        // Reset in RESP: the write already happened and stays.
        mdl[13] = merge(mdl[13], 32'h0BADF00D, 4'hF);
        start_req(4'hF, 32'h34, 32'h0BADF00D);
        wait_resp(lat);
        chk("resp_rst_lat", lat, W + 1);
        resetn = 1'b0;
        #1;
        chk("resp_rst_valid", 32'(b.resp_valid), 0);
        @(negedge clk);
        resetn = 1'b1;
        t_addr = 32'h34; #1;
        chk("resp_rst_word", t_data, mdl[13]);

        // Random traffic over a small, heavily aliased window.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            a[9:2] = 8'($urandom_range(0, 15));
            d = $urandom;
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            txn(we, a, d, $urandom_range(0, 3));
        end

        // Zero-wait instance: preload, then back-to-back reads.
        txn0(4'hF, 32'h0, 32'h01020304);
        txn0(4'hF, 32'h4, 32'hA5A55A5A);
        @(negedge clk);
        b0.req_valid = 1'b1; b0.req_wen = 4'h0; b0.req_addr = 32'h0; b0.resp_ready = 1'b1;
        chk("b2b_ready0", 32'(b0.req_ready), 1);
        @(negedge clk);
        b0.req_addr = 32'h4;
        chk("b2b_busy0", 32'(b0.resp_valid), 0);
        chk("b2b_nready0", 32'(b0.req_ready), 0);
        @(negedge clk);
        chk("b2b_valid0", 32'(b0.resp_valid), 1);
        chk("b2b_rdata0", b0.resp_rdata, mdl0[0]);
        @(negedge clk);
        chk("b2b_idle", 32'(b0.req_ready), 1);
        chk("b2b_gap", 32'(b0.resp_valid), 0);
        @(negedge clk);
        b0.req_valid = 1'b0;
        chk("b2b_busy1", 32'(b0.resp_valid), 0);
        @(negedge clk);
        chk("b2b_valid1", 32'(b0.resp_valid), 1);
        chk("b2b_rdata1", b0.resp_rdata, mdl0[1]);
        @(negedge clk);
        b0.resp_ready = 1'b0;
        chk("b2b_done", 32'(b0.resp_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, meaning the number of wait-state cycles inserted between request acceptance and the memory access (legal range 0..15).
REQ-002 Parameter DEPTH_LOG2, default 8, meaning the log2 of the word count (256 x 32-bit words).
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port resetn  input  1  reset, asynchronous, active-low.
REQ-005 Port req_valid  input  1  initiator presents a request.
REQ-006 Port req_ready  output  1  responder accepts a request this cycle.
REQ-007 Port req_wen  input  4  byte write enables; bit i writes byte lane i (bits 8i+7:8i); 4'b0000 means read.
REQ-008 Port req_addr  input  32  byte address; word index = req_addr[DEPTH_LOG2+1:2].
REQ-009 Port req_wdata  input  32  write data.
REQ-010 Port resp_valid  output  1  response available.
REQ-011 Port resp_ready  input  1  initiator consumes the response.
REQ-012 Port resp_rdata  output  32  response word.
REQ-013 Port test_addr  input  32  display byte address; word index = test_addr[DEPTH_LOG2+1:2].
REQ-014 Port test_data  output  32  display word, combinational read of the array.

Function
REQ-015 States: IDLE, BUSY, RESP; exactly one state active at a time.
REQ-016 IDLE: req_ready=1, resp_valid=0; on req_valid&req_ready, latch addr/wen/wdata, load cnt=WAIT_CYCLES, go BUSY.
REQ-017 BUSY: req_ready=0; each edge, if cnt!=0 then cnt-=1, else perform the access and go RESP.
REQ-018 Access, write (wen!=0): update only the enabled byte lanes of the latched word index; resp_rdata = merged post-write word.
REQ-019 Access, read (wen==0): resp_rdata = stored word; array unchanged.
REQ-020 Latency: with acceptance at edge E0, resp_valid rises after edge E0+WAIT_CYCLES+1 (WAIT_CYCLES=0 gives 1 cycle).
REQ-021 RESP: resp_valid=1; resp_rdata held stable until resp_valid&resp_ready; on that edge go IDLE; req_ready=0 in RESP (no request overlap).
REQ-022 Backpressure: resp_ready low holds RESP indefinitely; no further array modification occurs while in RESP.
REQ-023 Request inputs are sampled only at the acceptance edge; changes to them during BUSY/RESP have no effect.
REQ-024 Address bits [1:0] and bits above DEPTH_LOG2+1 are ignored (aliasing, no error).
REQ-025 test_data reflects the array combinationally; a write becomes visible on test_data immediately after its access edge.
REQ-026 cnt is 4 bits wide; it never decrements below 0.

Reset
REQ-027 resetn low forces IDLE asynchronously, with cnt=0, resp_valid=0, resp_rdata=0, and req_ready=0 while resetn is low.
REQ-028 Reset during BUSY aborts the request; if the access edge has not occurred, no array byte changes.
REQ-029 Reset during RESP discards the pending response; the already-performed write persists.
REQ-030 Array contents are not cleared by reset; they are zero at time 0 of simulation.
REQ-031 After resetn rises, the first edge samples IDLE with req_ready=1.

Verification
REQ-032 Write 0xDEADBEEF to addr 0x10 with wen=4'hF, then read 0x10 -> each resp_valid appears exactly 3 cycles after acceptance; read returns 0xDEADBEEF.
REQ-033 With word 0x11223344 at 0x20, write wen=4'b0101 with data 0xAABBCCDD -> resp_rdata and test_data(0x20) = 0x11BB33DD.
REQ-034 Hold resp_ready=0 for 10 cycles after a read -> resp_valid stays 1, resp_rdata stable, req_ready=0, and a concurrent req_valid is not accepted.
REQ-035 WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 with resp_ready=1 -> each response arrives 1 cycle after acceptance; one request completes every 3 cycles.
REQ-036 Assert resetn low in BUSY (cnt=1) of a write to 0x30 -> resp_valid=0 immediately; word at 0x30 unchanged; after release req_ready=1.
REQ-037 Write to addr 0x404 (aliases 0x004) -> test_addr=0x4 shows the written word.
